// File: rtl/sipo_pack.sv
// sipo_pack: serial-in/parallel-out packer.
// Collects DATA_IN_WIDTH-bit beats from a valid/ready stream and emits one
// DATA_OUT_WIDTH-bit word per NUM_BEATS accepted beats. The first accepted beat
// lands in the least-significant lane (lane k = bits [k*DATA_IN_WIDTH +: DATA_IN_WIDTH]).
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RESET      synchronous, active-high reset
//   IN_VALID   beat present on DATA_IN
//   DATA_IN    beat data
//   IN_READY   beat accepted this cycle (combinational, depends on OUT_READY)
//   IN_LAST    last beat of a partial word (only with SIPO_PACK_LAST_EN)
//   OUT_VALID  DATA_OUT holds a packed word
//   DATA_OUT   packed word
//   OUT_READY  consumer takes the word this cycle
//
// Optional feature: define SIPO_PACK_LAST_EN to add the IN_LAST port, which
// completes a word early with the unfilled upper lanes zeroed.

module sipo_pack #(
    parameter int unsigned DATA_IN_WIDTH  = 16,
    parameter int unsigned DATA_OUT_WIDTH = 64
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      IN_VALID,
    input  logic [DATA_IN_WIDTH-1:0]  DATA_IN,
    output logic                      IN_READY,
`ifdef SIPO_PACK_LAST_EN
    input  logic                      IN_LAST,
`endif
    output logic                      OUT_VALID,
    output logic [DATA_OUT_WIDTH-1:0] DATA_OUT,
    input  logic                      OUT_READY
);

    localparam int unsigned NUM_BEATS = DATA_OUT_WIDTH / DATA_IN_WIDTH;
    localparam int unsigned CNT_W     = $clog2(NUM_BEATS);
    localparam int unsigned ACC_W     = (NUM_BEATS - 1) * DATA_IN_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    if ((DATA_OUT_WIDTH % DATA_IN_WIDTH) != 0 || NUM_BEATS < 2) begin : g_param_check
        $error("sipo_pack: DATA_OUT_WIDTH must be a multiple (>= 2x) of DATA_IN_WIDTH");
    end

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_OUT_WIDTH-1:0] packed_word;

    logic last_beat;
    logic completing;
    logic out_free;
    logic accept;

`ifdef SIPO_PACK_LAST_EN
    // IN_LAST only means something when a beat is actually presented.
    assign last_beat = IN_VALID && IN_LAST;
`else
    assign last_beat = 1'b0;
`endif

    assign completing = (cnt_q == LAST_CNT) || last_beat;
    assign out_free   = !out_valid_q || OUT_READY;

    // Only the completing beat needs a free output register; the others go to acc.
    assign IN_READY = !RESET && (!completing || out_free);
    assign accept   = IN_VALID && IN_READY;

    // Lanes below cnt from acc, DATA_IN at lane cnt, everything above zero.
    always_comb begin
        packed_word = '0;
        for (int unsigned k = 0; k < NUM_BEATS - 1; k++) begin
            if (k < 32'(cnt_q)) begin
                packed_word[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] =
                    acc_q[k*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            end
        end
        for (int unsigned k = 0; k < NUM_BEATS; k++) begin
            if (k == 32'(cnt_q)) begin
                packed_word[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = DATA_IN;
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;

        if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (completing) begin
                // Overrides the handshake clear: a new word replaces the old one.
                out_valid_d = 1'b1;
                data_out_d  = packed_word;
                cnt_d       = '0;
                acc_d       = '0;
            end else begin
                for (int unsigned k = 0; k < NUM_BEATS - 1; k++) begin
                    if (k == 32'(cnt_q)) begin
                        acc_d[k*DATA_IN_WIDTH +: DATA_IN_WIDTH] = DATA_IN;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign DATA_OUT  = data_out_q;

endmodule
